// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying a data and a control payload between
// adjacent pipeline stages; master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 8
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush and bubble control.
// Define PIPE_SKID_EN to add a second (skid) entry that registers the upstream ready path.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       CTRL_W = 8,
  parameter logic [CTRL_W-1:0] BUBBLE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_stage_reg_if.slave         up,
  pipe_stage_reg_if.master        dn,
  input  logic                    flush,
  output logic [1:0]              occupancy
);

`ifdef PIPE_SKID_EN
  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;
`else
  typedef enum logic {ST_EMPTY = 1'b0, ST_ONE = 1'b1} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
`endif

  logic out_valid;
  logic in_ready;
  logic do_accept;
  logic do_release;

  assign out_valid  = (state_q != ST_EMPTY);
`ifdef PIPE_SKID_EN
  assign in_ready   = (state_q != ST_TWO);
  assign occupancy  = 2'(state_q);
`else
  assign in_ready   = ~out_valid | dn.ready;
  assign occupancy  = {1'b0, out_valid};
`endif
  assign do_accept  = up.valid & in_ready & ~flush;
  assign do_release = out_valid & dn.ready;

  assign up.ready = in_ready;
  assign dn.valid = out_valid;
  assign dn.data  = head_data_q;
  // Downstream write enables must stay inactive whenever no instruction is held.
  assign dn.ctrl  = out_valid ? head_ctrl_q : BUBBLE;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
`ifdef PIPE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (do_accept) begin
          state_d     = ST_ONE;
          head_data_d = up.data;
          head_ctrl_d = up.ctrl;
        end
      end
      ST_ONE: begin
        if (do_accept && do_release) begin
          head_data_d = up.data;
          head_ctrl_d = up.ctrl;
`ifdef PIPE_SKID_EN
        end else if (do_accept) begin
          state_d     = ST_TWO;
          skid_data_d = up.data;
          skid_ctrl_d = up.ctrl;
`endif
        end else if (do_release) begin
          state_d = ST_EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      ST_TWO: begin
        if (do_release) begin
          state_d     = ST_ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
        end
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= BUBBLE;
`ifdef PIPE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= BUBBLE;
`endif
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
`ifdef PIPE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
`endif
    end
  end

endmodule
